reaction_timer: RTL and testbench

- Downstream consumer of the 12-bit LFSR random value in the reaction-time game.
- On each round it pulses the LFSR advance strobe and captures the new value as a random pre-stimulus delay in milliseconds.
- It then lights the stimulus LED and measures the player's reaction time in milliseconds, reporting the result or a false-start/timeout condition to the display logic.

---
 rtl/reaction_timer_pkg.sv | 23 ++
 rtl/reaction_timer_ms_tick_gen.sv | 43 ++++
 rtl/reaction_timer.sv | 156 +++++++++++++++
 tb/tb_reaction_timer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction-time game: widths, default timing limits
// and the round state encoding.
package reaction_pkg;

  localparam int RESULT_W          = 14;
  localparam int DELAY_W           = 13;
  localparam int DEF_MIN_DELAY_MS  = 500;
  localparam int DEF_MAX_RESULT_MS = 9999;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REQ     = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_WAIT    = 3'd3;
  localparam state_t ST_MEASURE = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  function automatic logic is_busy(input state_t st);
    return (st == ST_REQ) || (st == ST_LOAD) || (st == ST_WAIT) || (st == ST_MEASURE);
  endfunction

endpackage

// File: rtl/reaction_timer_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICKS_PER_MS-1 and raises tick on the wrap cycle.
// A synchronous clear restarts the count so the next tick lands TICKS_PER_MS cycles later.
module ms_tick_gen #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_MS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // Next prescaler value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Prescaler register; tick is registered so it coincides with the wrap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time round controller: fetches a random pre-stimulus delay from the LFSR,
// lights the stimulus LED after it expires and measures the player's response in ms.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int TICKS_PER_MS  = 50000,
  parameter int MIN_DELAY_MS  = DEF_MIN_DELAY_MS,
  parameter int MAX_RESULT_MS = DEF_MAX_RESULT_MS,
  parameter int RAND_W        = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                react,
  input  logic [RAND_W-1:0]   rand_val,
  output logic                rand_req,
  output logic                stim_led,
  output logic                busy,
  output logic [RESULT_W-1:0] result_ms,
  output logic                result_valid,
  output logic                false_start,
  output logic                timeout
);

  localparam logic [RESULT_W-1:0] MAX_C = RESULT_W'(MAX_RESULT_MS);
  localparam logic [DELAY_W-1:0]  MIN_C = DELAY_W'(MIN_DELAY_MS);

  state_t              state_q, state_d;
  logic [RESULT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                valid_q, valid_d;
  logic                fs_q, fs_d;
  logic                to_q, to_d;
  logic                rand_req_q, stim_q, busy_q;
  logic                tick_s, clear_s;

  assign cnt_inc_s = cnt_q + {{(RESULT_W-1){1'b0}}, 1'b1};
  // The prescaler only runs inside WAIT/MEASURE and restarts on every state change.
  assign clear_s   = (state_d != state_q) || !((state_q == ST_WAIT) || (state_q == ST_MEASURE));

  ms_tick_gen #(.TICKS_PER_MS(TICKS_PER_MS)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Round state machine and result bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    result_d = result_q;
    valid_d  = valid_q;
    fs_d     = fs_q;
    to_d     = to_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_REQ;
          result_d = {RESULT_W{1'b0}};
          valid_d  = 1'b0;
          fs_d     = 1'b0;
          to_d     = 1'b0;
        end else begin
          state_d  = state_q;
        end
      end
      ST_REQ: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        delay_d = MIN_C + DELAY_W'(rand_val);
        cnt_d   = {RESULT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (react) begin
          state_d  = ST_DONE;
          fs_d     = 1'b1;
          result_d = {RESULT_W{1'b0}};
          valid_d  = 1'b0;
        end else if (tick_s) begin
          if (cnt_inc_s >= RESULT_W'(delay_q)) begin
            state_d = ST_MEASURE;
            cnt_d   = {RESULT_W{1'b0}};
          end else begin
            cnt_d   = cnt_inc_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_MEASURE: begin
        // react beats a coincident saturating tick and reports the count before it.
        if (react) begin
          state_d  = ST_DONE;
          result_d = cnt_q;
          valid_d  = 1'b1;
        end else if (tick_s) begin
          if (cnt_inc_s >= MAX_C) begin
            state_d  = ST_DONE;
            result_d = MAX_C;
            valid_d  = 1'b1;
            to_d     = 1'b1;
            cnt_d    = MAX_C;
          end else begin
            cnt_d    = cnt_inc_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {RESULT_W{1'b0}};
      delay_q    <= {DELAY_W{1'b0}};
      result_q   <= {RESULT_W{1'b0}};
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
      to_q       <= 1'b0;
      rand_req_q <= 1'b0;
      stim_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      delay_q    <= delay_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      fs_q       <= fs_d;
      to_q       <= to_d;
      rand_req_q <= (state_d == ST_REQ);
      stim_q     <= (state_d == ST_MEASURE);
      busy_q     <= is_busy(state_d);
    end
  end

  assign rand_req     = rand_req_q;
  assign stim_led     = stim_q;
  assign busy         = busy_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: each round's outcome and timeline is
// predicted arithmetically from the delay, tick period and react cycle.
module tb_reaction_timer;

  localparam int T    = 4;
  localparam int MINM = 5;
  localparam int MAXM = 20;
  localparam int RW   = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          react = 1'b0;
  logic [RW-1:0] rand_val = '0;
  logic          rand_req, stim_led, busy, result_valid, false_start, timeout;
  logic [13:0]   result_ms;

  int checks = 0;
  int errors = 0;

  // Last round outcome, used to verify DONE holds its result.
  int last_res;
  bit last_val, last_fs, last_to;

  reaction_timer #(
    .TICKS_PER_MS (T),
    .MIN_DELAY_MS (MINM),
    .MAX_RESULT_MS(MAXM),
    .RAND_W       (RW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .react        (react),
    .rand_val     (rand_val),
    .rand_req     (rand_req),
    .stim_led     (stim_led),
    .busy         (busy),
    .result_ms    (result_ms),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({rand_req, stim_led, busy, result_valid, false_start, timeout} !== 6'b0 || result_ms !== 14'd0) begin
      errors++;
      $display("FAIL %s: outputs req=%b led=%b busy=%b val=%b fs=%b to=%b res=%0d, required all 0",
               name, rand_req, stim_led, busy, result_valid, false_start, timeout, result_ms);
    end
  endtask

  // One round: start with random value r, react pulse in cycle c (counted from the
  // REQ cycle = 0), optional ignored start pulses, optional reset at cycle abort_at.
  task automatic run_round(input string name, input int r, input int c,
                           input bit inj_start, input int abort_at);
    int d, s, dd, exp_res;
    bit exp_fs, exp_to, exp_val, done, exp_busy, exp_stim, exp_rr;
    d = MINM + r;
    s = d * T + 2;
    exp_fs = 1'b0; exp_to = 1'b0; exp_val = 1'b1;
    if (c >= 2 && c < s) begin
      dd = c + 1; exp_fs = 1'b1; exp_val = 1'b0; exp_res = 0;
    end else if (c >= s && c <= s + MAXM * T - 1) begin
      dd = c + 1; exp_res = (c - s) / T;
    end else begin
      dd = s + MAXM * T; exp_res = MAXM; exp_to = 1'b1;
    end
    rand_val = RW'(r);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= dd + 2; i++) begin
      if (i == abort_at) begin
        react = 1'b0; start = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero({name, "_abort"});
        return;
      end
      exp_rr   = (i == 0);
      exp_busy = (i < dd);
      exp_stim = !exp_fs && (i >= s) && (i < dd);
      done     = (i >= dd);
      checks++;
      if ({rand_req, busy, stim_led} !== {exp_rr, exp_busy, exp_stim}) begin
        errors++;
        $display("FAIL %s_ctrl cyc %0d: req/busy/led=%b%b%b, required %b%b%b",
                 name, i, rand_req, busy, stim_led, exp_rr, exp_busy, exp_stim);
      end
      checks++;
      if ({result_valid, false_start, timeout} !== (done ? {exp_val, exp_fs, exp_to} : 3'b000)) begin
        errors++;
        $display("FAIL %s_flags cyc %0d: val/fs/to=%b%b%b, required %b%b%b", name, i,
                 result_valid, false_start, timeout, done & exp_val, done & exp_fs, done & exp_to);
      end
      checks++;
      if (result_ms !== (done ? 14'(exp_res) : 14'd0)) begin
        errors++;
        $display("FAIL %s_result cyc %0d: result_ms=%0d, required %0d", name, i,
                 result_ms, done ? exp_res : 0);
      end
      react = (i == c);
      start = inj_start && (i < dd) && ($urandom_range(0, 2) == 0);
      step();
    end
    react = 1'b0;
    start = 1'b0;
    last_res = exp_res; last_val = exp_val; last_fs = exp_fs; last_to = exp_to;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_all_zero("reset");
  endtask

  task automatic test_normal();
    // 8 ms delay; react one cycle into the 8th ms of MEASURE -> 7 ms.
    run_round("normal", 3, (MINM + 3) * T + 2 + 7 * T + 1, 1'b0, -1);
  endtask

  task automatic test_false_start();
    run_round("false_start", 6, 2 * T + 1, 1'b0, -1);
  endtask

  task automatic test_timeout();
    run_round("timeout", 1, 1000000, 1'b0, -1);
  endtask

  task automatic test_simultaneous();
    run_round("sim_expiry", 2, (MINM + 2) * T + 1, 1'b0, -1);
    run_round("sim_saturate", 0, MINM * T + 2 + MAXM * T - 1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_measure();
    run_round("reset_mid", 4, -1, 1'b0, (MINM + 4) * T + 2 + 5);
    run_round("after_reset", 2, (MINM + 2) * T + 2 + 3 * T, 1'b0, -1);
  endtask

  task automatic test_ignored();
    run_round("ign_busy", 5, (MINM + 5) * T + 2 + 11 * T + 2, 1'b1, -1);
    // react pulses in DONE must leave the held result untouched
    for (int i = 0; i < 8; i++) begin
      react = (i % 2 == 0);
      step();
      checks++;
      if ({busy, rand_req, stim_led, result_valid, false_start, timeout} !==
          {3'b000, last_val, last_fs, last_to} || result_ms !== 14'(last_res)) begin
        errors++;
        $display("FAIL done_hold cyc %0d: busy=%b val=%b fs=%b to=%b res=%0d, required busy=0 val=%b fs=%b to=%b res=%0d",
                 i, busy, result_valid, false_start, timeout, result_ms, last_val, last_fs, last_to, last_res);
      end
    end
    react = 1'b0;
    test_reset();
    for (int i = 0; i < 6; i++) begin
      react = (i % 2 == 1);
      step();
      check_all_zero("idle_react");
    end
    react = 1'b0;
  endtask

  task automatic test_random();
    int r, c, s;
    for (int k = 0; k < 10; k++) begin
      r = int'($urandom_range(0, 15));
      s = (MINM + r) * T + 2;
      c = int'($urandom_range(0, s + MAXM * T + 3));
      run_round("random", r, c, ($urandom_range(0, 1) == 1), -1);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_false_start();
    test_timeout();
    test_simultaneous();
    test_reset_mid_measure();
    test_ignored();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
